// File: rtl/lc2k_pkg.sv
// lc2k_pkg: shared opcode, sequencer state and datapath mux encodings for the LC2K multi-cycle core.
package lc2k_pkg;
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_NOR  = 3'd1;
   localparam logic [2:0] OP_LW   = 3'd2;
   localparam logic [2:0] OP_SW   = 3'd3;
   localparam logic [2:0] OP_BEQ  = 3'd4;
   localparam logic [2:0] OP_JALR = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd6;
   localparam logic [2:0] OP_NOOP = 3'd7;
   localparam logic [1:0] PC_INC  = 2'd0;
   localparam logic [1:0] PC_OFS  = 2'd1;
   localparam logic [1:0] PC_REGA = 2'd2;
   localparam logic [1:0] WD_ALU  = 2'd0;
   localparam logic [1:0] WD_MEM  = 2'd1;
   localparam logic [1:0] WD_PC1  = 2'd2;
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_ERROR} state_t;
endpackage

// File: rtl/lc2k_multicycle_ctrl_if.sv
// lc2k_multicycle_ctrl_if: status inputs and datapath/memory strobes between sequencer and datapath.
interface lc2k_multicycle_ctrl_if #(parameter int CNT_W = 32);
   logic [2:0] opcode;
   logic alu_eq, mem_ready;
   logic mem_req, mem_we, mem_addr_sel, ir_load, pc_load;
   logic [1:0] pc_sel;
   logic reg_write_en, write_reg_sel;
   logic [1:0] write_data_sel;
   logic alu_b_sel, alu_op, halted, error;
   logic [CNT_W-1:0] retired;
   modport master(
      input opcode, alu_eq, mem_ready,
      output mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_sel, reg_write_en,
             write_reg_sel, write_data_sel, alu_b_sel, alu_op, halted, error, retired
   );
   modport slave(
      output opcode, alu_eq, mem_ready,
      input mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_sel, reg_write_en,
            write_reg_sel, write_data_sel, alu_b_sel, alu_op, halted, error, retired
   );
endinterface

// File: rtl/lc2k_wait_timer.sv
// lc2k_wait_timer: memory wait counter; tc flags the last tolerated non-ready cycle.
module lc2k_wait_timer #(parameter int MAX_WAIT = 255) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc
);
   localparam logic [15:0] LAST = 16'(MAX_WAIT - 1);
   logic [15:0] cnt;
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (inc) cnt <= cnt + 16'd1;
   assign tc = cnt == LAST;
endmodule

// File: rtl/lc2k_multicycle_ctrl.sv
// lc2k_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving LC2K datapath strobes over one shared memory.
module lc2k_multicycle_ctrl
   import lc2k_pkg::*;
#(
   parameter int MAX_WAIT = 255,
   parameter int CNT_W = 32
) (
   input logic clk,
   input logic reset,
   lc2k_multicycle_ctrl_if.master bus
);
   state_t state;
   logic [CNT_W-1:0] count;
   logic tc, waiting, is_alu, is_mem, is_sw, is_lw;
   assign waiting = state == S_FETCH || state == S_MEM;
   assign is_alu = bus.opcode == OP_ADD || bus.opcode == OP_NOR;
   assign is_lw = bus.opcode == OP_LW;
   assign is_sw = bus.opcode == OP_SW;
   assign is_mem = is_lw || is_sw;
   lc2k_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
      .clk(clk),
      .rst(reset),
      .clr(!waiting || bus.mem_ready),
      .inc(waiting && !bus.mem_ready),
      .tc(tc)
   );
   always_ff @(posedge clk)
      if (reset) begin
         state <= S_FETCH;
         count <= '0;
      end else begin
         if (bus.pc_load) count <= count + 1'b1;
         case (state)
            S_FETCH:  state <= bus.mem_ready ? S_DECODE : tc ? S_ERROR : S_FETCH;
            S_DECODE: state <= S_EXEC;
            S_EXEC:   state <= is_alu ? S_WB : is_mem ? S_MEM : bus.opcode == OP_HALT ? S_HALTED : S_FETCH;
            S_MEM:    state <= bus.mem_ready ? (is_sw ? S_FETCH : S_WB) : tc ? S_ERROR : S_MEM;
            S_WB:     state <= S_FETCH;
            default:  state <= state;
         endcase
      end
   assign bus.retired = reset ? '0 : count;
   // Strobes are gated to zero for the whole reset cycle, aborting any access in flight.
   always_comb begin
      bus.mem_req = 1'b0;
      bus.mem_we = 1'b0;
      bus.mem_addr_sel = 1'b0;
      bus.ir_load = 1'b0;
      bus.pc_load = 1'b0;
      bus.pc_sel = PC_INC;
      bus.reg_write_en = 1'b0;
      bus.write_reg_sel = 1'b0;
      bus.write_data_sel = WD_ALU;
      bus.alu_b_sel = 1'b0;
      bus.alu_op = 1'b0;
      bus.halted = 1'b0;
      bus.error = 1'b0;
      if (!reset)
         case (state)
            S_FETCH: begin
               bus.mem_req = 1'b1;
               bus.ir_load = bus.mem_ready;
            end
            S_EXEC: begin
               bus.alu_b_sel = is_mem;
               bus.alu_op = bus.opcode == OP_NOR;
               bus.pc_load = !(is_alu || is_mem);
               bus.pc_sel = bus.opcode == OP_BEQ ? (bus.alu_eq ? PC_OFS : PC_INC)
                          : bus.opcode == OP_JALR ? PC_REGA : PC_INC;
               bus.reg_write_en = bus.opcode == OP_JALR;
               bus.write_data_sel = bus.opcode == OP_JALR ? WD_PC1 : WD_ALU;
            end
            S_MEM: begin
               bus.mem_req = 1'b1;
               bus.mem_addr_sel = 1'b1;
               bus.alu_b_sel = 1'b1;
               bus.mem_we = is_sw;
               bus.pc_load = bus.mem_ready && is_sw;
            end
            S_WB: begin
               bus.reg_write_en = 1'b1;
               bus.pc_load = 1'b1;
               bus.write_reg_sel = !is_lw;
               bus.write_data_sel = is_lw ? WD_MEM : WD_ALU;
            end
            S_HALTED: bus.halted = 1'b1;
            S_ERROR: begin
               bus.halted = 1'b1;
               bus.error = 1'b1;
            end
            default: ;
         endcase
   end
endmodule
